// File: rtl/hex_display_driver.sv
// Two-digit multiplexed seven-segment hex display driver with frame-aligned double-buffered loads.
// Optional macro LEADING_ZERO_BLANK_EN blanks the high digit when its nibble is zero.
module hex_display_driver #(
  parameter logic [15:0] REFRESH_DIV    = 16'd50000,
  parameter logic [3:0]  GAP_CYCLES     = 4'd8,
  parameter logic        SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       zero_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_en,
  output logic       frame_start,
  output logic       pending
);

  localparam logic [15:0] R_EFF = (REFRESH_DIV == 16'd0) ? 16'd1 : REFRESH_DIV;

  typedef enum logic [1:0] {SHOW_LO, GAP_LO, SHOW_HI, GAP_HI} state_e;

  state_e      state_q, state_d;
  logic [15:0] show_cnt_q, show_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  shown_q, shown_d, pend_val_q, pend_val_d;
  logic        shown_zero_q, shown_zero_d, pend_zero_q, pend_zero_d;
  logic        pending_q, pending_d, frame_start_q, frame_start_d;
  logic [6:0]  seg_q, seg_d, seg_lg;
  logic [1:0]  en_q, en_d, en_lg;
  logic        dp_q, dp_d, dp_lg;
  logic        boundary;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;  4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;  4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;  4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;  4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  // Counters are loaded with 1 on state entry; the reset GAP_HI starts from 0 and
  // so runs one extra cycle, placing the first SHOW_LO on edge GAP_CYCLES+1.
  always_comb begin
    state_d    = state_q;
    show_cnt_d = show_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    boundary   = 1'b0;
    unique case (state_q)
      SHOW_LO: begin
        if (show_cnt_q >= R_EFF) begin
          if (GAP_CYCLES == 4'd0) begin
            state_d    = SHOW_HI;
            show_cnt_d = 16'd1;
          end else begin
            state_d   = GAP_LO;
            gap_cnt_d = 4'd1;
          end
        end else begin
          show_cnt_d = show_cnt_q + 16'd1;
        end
      end
      GAP_LO: begin
        if (gap_cnt_q >= GAP_CYCLES) begin
          state_d    = SHOW_HI;
          show_cnt_d = 16'd1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      SHOW_HI: begin
        if (show_cnt_q >= R_EFF) begin
          if (GAP_CYCLES == 4'd0) begin
            state_d    = SHOW_LO;
            show_cnt_d = 16'd1;
            boundary   = 1'b1;
          end else begin
            state_d   = GAP_HI;
            gap_cnt_d = 4'd1;
          end
        end else begin
          show_cnt_d = show_cnt_q + 16'd1;
        end
      end
      GAP_HI: begin
        if (gap_cnt_q >= GAP_CYCLES) begin
          state_d    = SHOW_LO;
          show_cnt_d = 16'd1;
          boundary   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = GAP_HI;
    endcase
  end

  // Boundary promotion reads the old pending value; a same-edge load then refills it.
  always_comb begin
    shown_d       = shown_q;
    shown_zero_d  = shown_zero_q;
    pend_val_d    = pend_val_q;
    pend_zero_d   = pend_zero_q;
    pending_d     = pending_q;
    frame_start_d = 1'b0;
    if (boundary && pending_q) begin
      shown_d       = pend_val_q;
      shown_zero_d  = pend_zero_q;
      pending_d     = 1'b0;
      frame_start_d = 1'b1;
    end
    if (load) begin
      pend_val_d  = data_in;
      pend_zero_d = zero_in;
      pending_d   = 1'b1;
    end
  end

  always_comb begin
    seg_lg = '0;
    en_lg  = '0;
    dp_lg  = 1'b0;
    unique case (state_d)
      SHOW_LO: begin
        en_lg  = 2'b01;
        seg_lg = decode(shown_d[3:0]);
      end
      SHOW_HI: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (shown_d[7:4] != 4'h0) begin
          en_lg  = 2'b10;
          seg_lg = decode(shown_d[7:4]);
          dp_lg  = shown_zero_d;
        end
`else
        en_lg  = 2'b10;
        seg_lg = decode(shown_d[7:4]);
        dp_lg  = shown_zero_d;
`endif
      end
      default: ;
    endcase
    seg_d = seg_lg ^ {7{SEG_ACTIVE_LOW}};
    en_d  = en_lg ^ {2{SEG_ACTIVE_LOW}};
    dp_d  = dp_lg ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= GAP_HI;
      show_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      shown_q       <= '0;
      shown_zero_q  <= 1'b0;
      pend_val_q    <= '0;
      pend_zero_q   <= 1'b0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= {7{SEG_ACTIVE_LOW}};
      en_q          <= {2{SEG_ACTIVE_LOW}};
      dp_q          <= SEG_ACTIVE_LOW;
    end else begin
      state_q       <= state_d;
      show_cnt_q    <= show_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      shown_q       <= shown_d;
      shown_zero_q  <= shown_zero_d;
      pend_val_q    <= pend_val_d;
      pend_zero_q   <= pend_zero_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      en_q          <= en_d;
      dp_q          <= dp_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign digit_en    = en_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: timing/content model from frame arithmetic plus literal pins.
// A second instance with no gap cycles checks the back-to-back digit sequence.
module tb_hex_display_driver;

  localparam int R  = 4;
  localparam int G  = 2;
  localparam int P  = 2 * (R + G);
  localparam int P0 = 2 * R;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       load = 1'b0;
  logic       zero_in = 1'b0;
  logic       load0 = 1'b0;
  logic [6:0] seg, seg0;
  logic       dp, dp0, fs, fs0, pend, pend0;
  logic [1:0] en, en0;

  hex_display_driver #(.REFRESH_DIV(16'd4), .GAP_CYCLES(4'd2), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .zero_in(zero_in),
    .seg(seg), .dp(dp), .digit_en(en), .frame_start(fs), .pending(pend));

  hex_display_driver #(.REFRESH_DIV(16'd4), .GAP_CYCLES(4'd0), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load0), .zero_in(zero_in),
    .seg(seg0), .dp(dp0), .digit_en(en0), .frame_start(fs0), .pending(pend0));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: k counts edges since reset release; content follows the double-buffer rules.
  int         k;
  logic [7:0] m_shown, m_pend;
  logic       m_sz, m_pz, m_pending, m_fs;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  function automatic int phase(input int kk, input int g, input int per);
    if (kk <= g) return -1;
    return (kk - g - 1) % per;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; m_shown = '0; m_pend = '0; m_sz = 0; m_pz = 0; m_pending = 0; m_fs = 0;
  endtask

  task automatic model_edge(input logic ld, input logic [7:0] d, input logic z);
    k++;
    m_fs = 0;
    if (phase(k, G, P) == 0 && m_pending) begin
      m_shown = m_pend; m_sz = m_pz; m_pending = 0; m_fs = 1;
    end
    if (ld) begin
      m_pend = d; m_pz = z; m_pending = 1;
    end
  endtask

  task automatic compare_cycle();
    int ph, ph0;
    logic [6:0] es, es0;
    logic [1:0] ee, ee0;
    logic ed;
    ph = phase(k, G, P);
    es = '0; ee = '0; ed = 0;
    if (ph >= 0 && ph < R) begin
      ee = 2'b01; es = hex7[m_shown[3:0]];
    end else if (ph >= R + G && ph < 2 * R + G) begin
      if (!(BLANK && m_shown[7:4] == 4'h0)) begin
        ee = 2'b10; es = hex7[m_shown[7:4]]; ed = m_sz;
      end
    end
    chk("seg", {1'b0, seg}, {1'b0, es});
    chk("digit_en", {6'b0, en}, {6'b0, ee});
    chk("dp", {7'b0, dp}, {7'b0, ed});
    chk("frame_start", {7'b0, fs}, {7'b0, m_fs});
    chk("pending", {7'b0, pend}, {7'b0, m_pending});
    ph0 = phase(k, 0, P0);
    if (ph0 < R) begin
      ee0 = 2'b01; es0 = 7'h3F;
    end else if (BLANK) begin
      ee0 = 2'b00; es0 = 7'h00;
    end else begin
      ee0 = 2'b10; es0 = 7'h3F;
    end
    chk("g0_digit_en", {6'b0, en0}, {6'b0, ee0});
    chk("g0_seg", {1'b0, seg0}, {1'b0, es0});
    chk("g0_flags", {5'b0, dp0, fs0, pend0}, 8'h00);
  endtask

  task automatic step(input logic ld, input logic [7:0] d, input logic z);
    load = ld; data_in = d; zero_in = z;
    @(posedge clk);
    model_edge(ld, d, z);
    #1;
    compare_cycle();
    load = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic go_to(input int t);
    int n;
    n = 0;
    while (phase(k, G, P) != t && n < 3 * P) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("go_to_phase", 8'(phase(k, G, P)), 8'(t));
  endtask

  task automatic do_reset();
    #1;
    rst_n = 0;
    #2;
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_flags", {3'b0, en, dp, fs, pend}, 8'h00);
    chk("rst_g0", {1'b0, seg0}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    idle(3);
    chk("first_lo_seg", {1'b0, seg}, 8'h3F);
    chk("first_lo_en", {6'b0, en}, 8'h01);
    idle(12);

    go_to(2);
    step(1'b1, 8'hA7, 1'b0);
    chk("A7_pending", {7'b0, pend}, 8'h01);
    go_to(0);
    chk("A7_lo", {1'b0, seg}, 8'h07);
    chk("A7_fs", {7'b0, fs}, 8'h01);
    go_to(6);
    chk("A7_hi", {1'b0, seg}, 8'h77);
    chk("A7_hi_en", {6'b0, en}, 8'h02);

    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    go_to(0);
    chk("3C_lo", {1'b0, seg}, 8'h39);
    go_to(6);
    chk("3C_hi", {1'b0, seg}, 8'h4F);
    go_to(1);
    go_to(0);
    chk("3C_single_fs", {7'b0, fs}, 8'h00);

    step(1'b1, 8'h5E, 1'b0);
    go_to(11);
    step(1'b1, 8'h00, 1'b1);
    chk("5E_lo", {1'b0, seg}, 8'h79);
    chk("5E_pending_kept", {7'b0, pend}, 8'h01);
    go_to(6);
    chk("5E_hi", {1'b0, seg}, 8'h6D);
    go_to(0);
    chk("00_lo", {1'b0, seg}, 8'h3F);
    chk("00_fs", {7'b0, fs}, 8'h01);
    go_to(6);
`ifdef LEADING_ZERO_BLANK_EN
    chk("00_hi_blank", {1'b0, seg}, 8'h00);
`else
    chk("00_hi_dp", {7'b0, dp}, 8'h01);
`endif

    step(1'b1, 8'h09, 1'b0);
    go_to(0);
    chk("09_lo", {1'b0, seg}, 8'h6F);
    go_to(6);
`ifdef LEADING_ZERO_BLANK_EN
    chk("09_hi_en", {6'b0, en}, 8'h00);
    chk("09_hi_seg", {1'b0, seg}, 8'h00);
`else
    chk("09_hi_en", {6'b0, en}, 8'h02);
    chk("09_hi_seg", {1'b0, seg}, 8'h3F);
`endif

    step(1'b1, 8'h55, 1'b0);
    idle(1);
    do_reset();
    idle(3);
    chk("post_rst_lo", {1'b0, seg}, 8'h3F);
    chk("post_rst_pending", {7'b0, pend}, 8'h00);
    go_to(6);
    go_to(0);
    idle(P);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
- Output-side counterpart of the keypad encoder path: takes the 8-bit ALU result and drives a time-multiplexed two-digit seven-segment hex display.
- Loads are double-buffered and take effect only at a frame boundary, so a digit never tears mid-scan.
- Inserts dead-time gaps between digits to suppress ghosting.
- Sits after the ALU in the top level; its outputs go to dedicated/bidirectional output pins.

Parameters:
- REFRESH_DIV, 16'd50000, clock cycles each digit is lit per frame; 0 treated as 1.
- GAP_CYCLES, 4'd8, blank cycles between digits; 0 skips the gap states.
- SEG_ACTIVE_LOW, 1'b0, 1 inverts seg, dp and digit_en at the pins (common-anode board).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- data_in  input  8  value to display (ALU output).
- load  input  1  capture strobe, sampled every rising edge.
- zero_in  input  1  ALU zero flag, captured alongside data_in.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high before SEG_ACTIVE_LOW.
- dp  output  1  decimal point; shows the latched zero flag on the high digit.
- digit_en  output  2  one-hot digit select: [0] low nibble, [1] high nibble.
- frame_start  output  1  one-cycle pulse when a new frame begins with updated content.
- pending  output  1  high while a loaded value waits for the next frame boundary.

Behaviour:
- All outputs are registered and change only on rising clk edges or on asynchronous reset.
- Reset (rst_n low, asynchronous):
  - FSM enters GAP_HI with gap counter cleared.
  - Shown and pending value/flag registers = 0; pending = 0.
  - seg = 0, dp = 0, digit_en = 00, frame_start = 0 (logical levels; pins follow SEG_ACTIVE_LOW).
- FSM states: SHOW_LO -> GAP_LO -> SHOW_HI -> GAP_HI -> SHOW_LO.
  - SHOW_LO: lasts REFRESH_DIV cycles; digit_en = 01; seg = decode(shown[3:0]); dp = 0.
  - GAP_LO and GAP_HI: each lasts GAP_CYCLES cycles; digit_en = 00; seg = 0; dp = 0. With GAP_CYCLES = 0 the state is bypassed (SHOW -> SHOW directly).
  - SHOW_HI: lasts REFRESH_DIV cycles; digit_en = 10; seg = decode(shown[7:4]); dp = shown_zero.
- Frame period = 2*(REFRESH_DIV+GAP_CYCLES) cycles.
- After reset release, the first SHOW_LO begins on the (GAP_CYCLES+1)th rising edge with rst_n high (the 1st edge when GAP_CYCLES = 0).
- Load:
  - load = 1 at an edge: pend_val <= data_in, pend_zero <= zero_in, pending <= 1.
  - Repeated loads before a boundary: last one wins.
- Frame boundary (the edge entering SHOW_LO): if pending was 1 before that edge, then shown <= pend_val, shown_zero <= pend_zero, pending <= 0, frame_start = 1 for that cycle.
  - If pending was 0: shown is unchanged and frame_start = 0.
- Load on the same edge as a boundary: the prior pending value (if any) is displayed. The new load is captured into pending and pending = 1, so it is displayed next frame.
- Decode, hex to {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Counters:
  - 16-bit show counter and 4-bit gap counter, reloaded on each state entry.
  - No wrap beyond the terminal count.
- Mid-operation reset: immediate return to reset values; in-flight pending data is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in SHOW_HI, if shown[7:4] == 0, then digit_en = 00, seg = 0 and dp = 0 for the whole state. State timing is unchanged.
- Undefined: the high digit is always lit, showing "0" (3F) for values below 0x10.

Test Plan (REFRESH_DIV=4, GAP_CYCLES=2, SEG_ACTIVE_LOW=0):
- Reset then idle: outputs 0 during reset. First SHOW_LO after 3 edges, seg=3F, digit_en=01 for 4 cycles. Then 2 blank cycles, then SHOW_HI seg=3F, digit_en=10. Frame period = 12 cycles.
- Pulse load with data_in=8'hA7, zero_in=0 mid-frame: pending=1 until the next boundary. Then frame_start pulses once and pending=0. Low digit seg=07, high digit seg=77, dp=0.
- Two loads (8'h12 then 8'h3C) within one frame: only 3C is shown (low 39, high 4F); a single frame_start pulse.
- Load 8'h00, zero_in=1 on the boundary edge while 8'h5E is pending: 5E frame shown (low 79, high 6D). pending stays 1. Next frame shows 00 with dp=1 on the high digit.
- GAP_CYCLES=0 build: digit_en goes 01 -> 10 on consecutive cycles, never 00 after the first frame. Frame period = 8 cycles.
- With LEADING_ZERO_BLANK_EN, load 8'h09: low digit seg=6F; during SHOW_HI digit_en=00, seg=0. Without the macro: high digit seg=3F.
